// File: rtl/trap_csr_unit_if.sv
// CSR access bus between the machine CSR file decoder and the trap-state block.
// The master presents address/op/operand; the slave returns registered read data and hit.
interface trap_csr_unit_if #(
  parameter int XLEN = 32
);
  logic [11:0]     csr_addr_in;
  logic [1:0]      csr_op_in;
  logic [XLEN-1:0] csr_wdata_in;
  logic [XLEN-1:0] csr_rdata_out;
  logic            csr_hit_out;

  modport master (
    output csr_addr_in, csr_op_in, csr_wdata_in,
    input  csr_rdata_out, csr_hit_out
  );

  modport slave (
    input  csr_addr_in, csr_op_in, csr_wdata_in,
    output csr_rdata_out, csr_hit_out
  );
endinterface

// File: rtl/trap_csr_unit.sv
// Machine-mode trap-state CSRs (mepc, mcause, mtval) with prioritised trap capture,
// CSR write/set/clear access, registered read-back and a lock FSM against nested traps.
module trap_csr_unit #(
  parameter int XLEN         = 32,
  parameter bit ILL_TVAL_EN  = 1'b1,
  parameter bit LOCK_ON_TRAP = 1'b1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] iadder_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic            instr_mis_in,
  input  logic            ill_instr_in,
  input  logic            ld_mis_in,
  input  logic            st_mis_in,
  input  logic            irq_valid_in,
  input  logic [3:0]      irq_code_in,
  input  logic            mret_in,
  trap_csr_unit_if.slave  csr,
  output logic [XLEN-1:0] mepc_out,
  output logic [XLEN-1:0] mcause_out,
  output logic [XLEN-1:0] mtval_out,
  output logic            trap_taken_out,
  output logic            trapped_out,
  output logic            nested_out
);

  localparam logic [11:0]     ADDR_MEPC   = 12'h341;
  localparam logic [11:0]     ADDR_MCAUSE = 12'h342;
  localparam logic [11:0]     ADDR_MTVAL  = 12'h343;
  localparam logic [XLEN-1:0] MEPC_MASK   = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic {IDLE, TRAPPED} state_e;

  state_e          state_q, state_d;
  logic            nested_q, nested_d;
  logic            taken_q;
  logic            capture;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            hit_q, hit_d;
  logic            trap_evt, cap_irq;
  logic [3:0]      cap_code;
  logic [XLEN-1:0] cap_tval, cap_cause;

  function automatic logic [XLEN-1:0] csr_apply(input logic [XLEN-1:0] old,
                                                input logic [1:0]      op,
                                                input logic [XLEN-1:0] wd);
    case (op)
      2'b01:   return wd;
      2'b10:   return old | wd;
      2'b11:   return old & ~wd;
      default: return old;
    endcase
  endfunction

  assign trap_evt = instr_mis_in | ill_instr_in | ld_mis_in | st_mis_in | irq_valid_in;

  // Fixed priority: the first asserted source decides cause and tval.
  always_comb begin
    cap_code = 4'd0;
    cap_irq  = 1'b0;
    cap_tval = '0;
    if (instr_mis_in) begin
      cap_code = 4'd0;
      cap_tval = iadder_in;
    end else if (ill_instr_in) begin
      cap_code = 4'd2;
      cap_tval = ILL_TVAL_EN ? instr_in : '0;
    end else if (ld_mis_in) begin
      cap_code = 4'd4;
      cap_tval = iadder_in;
    end else if (st_mis_in) begin
      cap_code = 4'd6;
      cap_tval = iadder_in;
    end else if (irq_valid_in) begin
      cap_code = irq_code_in;
      cap_irq  = 1'b1;
    end
  end

  assign cap_cause = cap_irq ? {1'b1, {(XLEN-5){1'b0}}, cap_code}
                             : {{(XLEN-4){1'b0}}, cap_code};

  // mret is resolved before a same-cycle trap, so that trap is captured fresh.
  always_comb begin
    state_d  = state_q;
    nested_d = nested_q;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trap_evt) begin
          capture = 1'b1;
          state_d = TRAPPED;
        end
      end
      TRAPPED: begin
        if (mret_in) begin
          nested_d = 1'b0;
          if (trap_evt) capture = 1'b1;
          else          state_d = IDLE;
        end else if (trap_evt) begin
          if (LOCK_ON_TRAP) nested_d = 1'b1;
          else              capture  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    if (capture) begin
      mepc_d   = pc_in & MEPC_MASK;
      mcause_d = cap_cause;
      mtval_d  = cap_tval;
    end else if (csr.csr_op_in != 2'b00) begin
      case (csr.csr_addr_in)
        ADDR_MEPC:   mepc_d   = csr_apply(mepc_q, csr.csr_op_in, csr.csr_wdata_in) & MEPC_MASK;
        ADDR_MCAUSE: mcause_d = csr_apply(mcause_q, csr.csr_op_in, csr.csr_wdata_in);
        ADDR_MTVAL:  mtval_d  = csr_apply(mtval_q, csr.csr_op_in, csr.csr_wdata_in);
        default: ;
      endcase
    end
  end

  // Read-back reflects contents before this cycle's update.
  always_comb begin
    rdata_d = '0;
    hit_d   = 1'b1;
    case (csr.csr_addr_in)
      ADDR_MEPC:   rdata_d = mepc_q;
      ADDR_MCAUSE: rdata_d = mcause_q;
      ADDR_MTVAL:  rdata_d = mtval_q;
      default:     hit_d   = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      nested_q <= 1'b0;
      taken_q  <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      nested_q <= nested_d;
      taken_q  <= capture;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
    end
  end

  assign mepc_out          = mepc_q;
  assign mcause_out        = mcause_q;
  assign mtval_out         = mtval_q;
  assign trap_taken_out    = taken_q;
  assign trapped_out       = (state_q == TRAPPED);
  assign nested_out        = nested_q;
  assign csr.csr_rdata_out = rdata_q;
  assign csr.csr_hit_out   = hit_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed bench for trap_csr_unit: default, ILL_TVAL_EN=0 and LOCK_ON_TRAP=0 instances
// share one stimulus stream and are checked against hand-computed values.
module tb_trap_csr_unit;
  localparam int XLEN = 32;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [XLEN-1:0] pc_in, iadder_in, instr_in;
  logic            instr_mis_in, ill_instr_in, ld_mis_in, st_mis_in, irq_valid_in, mret_in;
  logic [3:0]      irq_code_in;
  logic [11:0]     addr;
  logic [1:0]      op;
  logic [XLEN-1:0] wdata;

  logic [XLEN-1:0] mepc0, mcause0, mtval0, mepc1, mcause1, mtval1, mepc2, mcause2, mtval2;
  logic            tk0, tr0, ne0, tk1, tr1, ne1, tk2, tr2, ne2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  trap_csr_unit_if #(.XLEN(XLEN)) bus0 ();
  trap_csr_unit_if #(.XLEN(XLEN)) bus1 ();
  trap_csr_unit_if #(.XLEN(XLEN)) bus2 ();

  assign bus0.csr_addr_in = addr;  assign bus0.csr_op_in = op;  assign bus0.csr_wdata_in = wdata;
  assign bus1.csr_addr_in = addr;  assign bus1.csr_op_in = op;  assign bus1.csr_wdata_in = wdata;
  assign bus2.csr_addr_in = addr;  assign bus2.csr_op_in = op;  assign bus2.csr_wdata_in = wdata;

  trap_csr_unit #(.XLEN(XLEN), .ILL_TVAL_EN(1'b1), .LOCK_ON_TRAP(1'b1)) u0 (
    .clk_in(clk_in), .rst_in(rst_in), .pc_in(pc_in), .iadder_in(iadder_in), .instr_in(instr_in),
    .instr_mis_in(instr_mis_in), .ill_instr_in(ill_instr_in), .ld_mis_in(ld_mis_in),
    .st_mis_in(st_mis_in), .irq_valid_in(irq_valid_in), .irq_code_in(irq_code_in),
    .mret_in(mret_in), .csr(bus0.slave), .mepc_out(mepc0), .mcause_out(mcause0),
    .mtval_out(mtval0), .trap_taken_out(tk0), .trapped_out(tr0), .nested_out(ne0));

  trap_csr_unit #(.XLEN(XLEN), .ILL_TVAL_EN(1'b0), .LOCK_ON_TRAP(1'b1)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .pc_in(pc_in), .iadder_in(iadder_in), .instr_in(instr_in),
    .instr_mis_in(instr_mis_in), .ill_instr_in(ill_instr_in), .ld_mis_in(ld_mis_in),
    .st_mis_in(st_mis_in), .irq_valid_in(irq_valid_in), .irq_code_in(irq_code_in),
    .mret_in(mret_in), .csr(bus1.slave), .mepc_out(mepc1), .mcause_out(mcause1),
    .mtval_out(mtval1), .trap_taken_out(tk1), .trapped_out(tr1), .nested_out(ne1));

  trap_csr_unit #(.XLEN(XLEN), .ILL_TVAL_EN(1'b1), .LOCK_ON_TRAP(1'b0)) u2 (
    .clk_in(clk_in), .rst_in(rst_in), .pc_in(pc_in), .iadder_in(iadder_in), .instr_in(instr_in),
    .instr_mis_in(instr_mis_in), .ill_instr_in(ill_instr_in), .ld_mis_in(ld_mis_in),
    .st_mis_in(st_mis_in), .irq_valid_in(irq_valid_in), .irq_code_in(irq_code_in),
    .mret_in(mret_in), .csr(bus2.slave), .mepc_out(mepc2), .mcause_out(mcause2),
    .mtval_out(mtval2), .trap_taken_out(tk2), .trapped_out(tr2), .nested_out(ne2));

  task automatic chk(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_in();
    instr_mis_in = 0; ill_instr_in = 0; ld_mis_in = 0; st_mis_in = 0;
    irq_valid_in = 0; irq_code_in = 4'd0; mret_in = 0;
    op = 2'b00; addr = 12'h000; wdata = '0;
  endtask

  task automatic csr_cycle(input logic [11:0] a, input logic [1:0] o, input logic [XLEN-1:0] d);
    addr = a; op = o; wdata = d;
    tick();
    op = 2'b00;
  endtask

  initial begin
    idle_in();
    pc_in = '0; iadder_in = '0; instr_in = '0;
    rst_in = 1'b1;
    tick(); tick();
    chk("rst_mepc", mepc0, 32'h0);
    chk("rst_mcause", mcause0, 32'h0);
    chk("rst_mtval", mtval0, 32'h0);
    chk("rst_flags", {29'd0, tk0, tr0, ne0}, 32'h0);
    chk("rst_rd", {bus0.csr_rdata_out[30:0], bus0.csr_hit_out}, 32'h0);
    rst_in = 1'b0;

    // load misaligned capture
    ld_mis_in = 1; pc_in = 32'h100; iadder_in = 32'h203;
    tick(); idle_in();
    chk("ld_mepc", mepc0, 32'h100);
    chk("ld_mcause", mcause0, 32'h4);
    chk("ld_mtval", mtval0, 32'h203);
    chk("ld_taken", {31'd0, tk0}, 32'h1);
    chk("ld_trapped", {31'd0, tr0}, 32'h1);
    tick();
    chk("pulse_one_cycle", {31'd0, tk0}, 32'h0);

    // nested trap: locked vs overwrite
    st_mis_in = 1; pc_in = 32'h503; iadder_in = 32'h777;
    tick(); idle_in();
    chk("lock_mcause", mcause0, 32'h4);
    chk("lock_mtval", mtval0, 32'h203);
    chk("lock_mepc", mepc0, 32'h100);
    chk("lock_nested", {31'd0, ne0}, 32'h1);
    chk("lock_no_pulse", {31'd0, tk0}, 32'h0);
    chk("nolock_mcause", mcause2, 32'h6);
    chk("nolock_mtval", mtval2, 32'h777);
    chk("nolock_mepc", mepc2, 32'h500);
    chk("nolock_pulse", {31'd0, tk2}, 32'h1);
    chk("nolock_nested", {31'd0, ne2}, 32'h0);
    mret_in = 1;
    tick(); idle_in();
    chk("mret_trapped", {31'd0, tr0}, 32'h0);
    chk("mret_nested", {31'd0, ne0}, 32'h0);

    // simultaneous sources: instr_mis wins
    instr_mis_in = 1; ill_instr_in = 1; irq_valid_in = 1; irq_code_in = 4'd3;
    pc_in = 32'h40; iadder_in = 32'h42; instr_in = 32'hDEAD_BEEF;
    tick(); idle_in();
    chk("prio_mcause", mcause0, 32'h0);
    chk("prio_mtval", mtval0, 32'h42);
    chk("prio_mepc", mepc0, 32'h40);
    mret_in = 1; tick(); idle_in();

    // illegal instruction tval with and without ILL_TVAL_EN
    ill_instr_in = 1; pc_in = 32'h44; instr_in = 32'hFFFF_FFFF;
    tick(); idle_in();
    chk("ill_mcause", mcause0, 32'h2);
    chk("ill_mtval", mtval0, 32'hFFFF_FFFF);
    chk("ill_mtval_off", mtval1, 32'h0);
    mret_in = 1; tick(); idle_in();

    // CSR write/set/clear on MTVAL, then MEPC low bits forced to zero
    csr_cycle(12'h343, 2'b01, 32'hA5A5_A5A5);
    csr_cycle(12'h343, 2'b10, 32'h0000_000F);
    csr_cycle(12'h343, 2'b11, 32'hA000_0000);
    chk("csr_mtval", mtval0, 32'h05A5_A5AF);
    chk("csr_rd_preupd", bus0.csr_rdata_out, 32'hA5A5_A5AF);
    chk("csr_hit", {31'd0, bus0.csr_hit_out}, 32'h1);
    csr_cycle(12'h341, 2'b01, 32'h1237);
    chk("csr_mepc", mepc0, 32'h1234);
    csr_cycle(12'h300, 2'b01, 32'h1111_1111);
    chk("csr_miss_noop", mepc0, 32'h1234);

    // capture beats same-cycle CSR write
    ld_mis_in = 1; pc_in = 32'h200; iadder_in = 32'h333;
    addr = 12'h343; op = 2'b01; wdata = 32'h1234_5678;
    tick(); idle_in();
    chk("cap_beats_wr", mtval0, 32'h333);
    mret_in = 1; tick(); idle_in();

    // interrupt capture
    irq_valid_in = 1; irq_code_in = 4'd7; pc_in = 32'h88; iadder_in = 32'h99;
    tick(); idle_in();
    chk("irq_mcause", mcause0, 32'h8000_0007);
    chk("irq_mtval", mtval0, 32'h0);
    chk("irq_mepc", mepc0, 32'h88);

    // registered read-back
    addr = 12'h342; tick();
    chk("rd_mcause", bus0.csr_rdata_out, 32'h8000_0007);
    chk("rd_hit", {31'd0, bus0.csr_hit_out}, 32'h1);
    addr = 12'h300; tick();
    chk("rd_miss_data", bus0.csr_rdata_out, 32'h0);
    chk("rd_miss_hit", {31'd0, bus0.csr_hit_out}, 32'h0);

    // mret + trap same cycle while trapped: fresh capture, nested cleared
    st_mis_in = 1; iadder_in = 32'h55; tick(); idle_in();
    chk("pre_both_nested", {31'd0, ne0}, 32'h1);
    mret_in = 1; ill_instr_in = 1; pc_in = 32'h60; instr_in = 32'h0000_0013;
    tick(); idle_in();
    chk("both_mcause", mcause0, 32'h2);
    chk("both_mtval", mtval0, 32'h13);
    chk("both_flags", {29'd0, tk0, tr0, ne0}, 32'h6);

    // reset while trapped and nested
    st_mis_in = 1; tick(); idle_in();
    chk("pre_rst_nested", {31'd0, ne0}, 32'h1);
    rst_in = 1; ld_mis_in = 1; addr = 12'h342; tick(); idle_in(); rst_in = 0;
    chk("rst2_mepc", mepc0, 32'h0);
    chk("rst2_mcause", mcause0, 32'h0);
    chk("rst2_mtval", mtval0, 32'h0);
    chk("rst2_flags", {29'd0, tk0, tr0, ne0}, 32'h0);
    chk("rst2_rd", {bus0.csr_rdata_out[30:0], bus0.csr_hit_out}, 32'h0);
    ld_mis_in = 1; pc_in = 32'h10; iadder_in = 32'h11; tick(); idle_in();
    chk("rst2_idle_capture", {31'd0, tk0}, 32'h1);
    chk("rst2_idle_mcause", mcause0, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
